// File: rtl/acq_sched.sv
// acq_sched: arms on frame sync, requests one conversion per sample clock edge, serialises enabled channels into a framed write stream
module acq_sched #(
    parameter int CHN_NUM       = 8,
    parameter int DATA_NBIT     = 16,
    parameter int FRAME_SAMPLES = 137,
    parameter int TIMEOUT       = 200
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         sync,
    input  logic                         spclk,
    input  logic [CHN_NUM-1:0]           chn_mask,
    output logic                         conv_start,
    input  logic                         conv_vd,
    input  logic [CHN_NUM*DATA_NBIT-1:0] conv_data,
    output logic                         wr,
    output logic [DATA_NBIT-1:0]         wdata,
    output logic [2:0]                   wchn,
    output logic                         sop,
    output logic                         eop,
    output logic [15:0]                  frame_cnt,
    output logic                         err_timeout,
    output logic                         err_overrun,
    output logic                         err_sync,
    output logic                         active
);
    typedef enum logic [2:0] {IDLE, WAIT_SYNC, WAIT_SPCLK, CONV, SCAN} state_t;
    state_t state, state_nx;
    logic sync_d, spclk_d, sync_rise, spclk_rise;
    logic [CHN_NUM-1:0] mask_lat, rem, src_mask, rest;
    logic [CHN_NUM*DATA_NBIT-1:0] data_lat, src_data;
    logic [15:0] tmo_cnt;
    logic [7:0] sample_cnt;
    logic [2:0] idx;
    logic last_sample, emit, last_word, go_conv, start_frame, set_sync, timeout, clear_err;

    assign sync_rise   = sync & ~sync_d;
    assign spclk_rise  = spclk & ~spclk_d;
    assign last_sample = sample_cnt == 8'(FRAME_SAMPLES - 1);
    assign src_mask    = (state == CONV) ? mask_lat : rem;
    assign src_data    = (state == CONV) ? conv_data : data_lat;
    assign emit        = (state == CONV && conv_vd) || (state == SCAN && rem != '0);
    assign last_word   = rest == '0;
    assign go_conv     = state == WAIT_SPCLK && state_nx == CONV;
    assign clear_err   = state == IDLE && en;
    assign active      = state != IDLE;

    // Pick the lowest pending channel; the first word comes straight from conv_data so it leaves one cycle after conv_vd
    always_comb begin
        idx = '0;
        for (int i = CHN_NUM - 1; i >= 0; i--) if (src_mask[i]) idx = 3'(i);
        rest = src_mask & ~({{(CHN_NUM-1){1'b0}}, 1'b1} << idx);
    end

    // Next-state logic and frame control strobes
    always_comb begin
        state_nx    = state;
        start_frame = 1'b0;
        set_sync    = 1'b0;
        timeout     = 1'b0;
        case (state)
            IDLE:       state_nx = en ? WAIT_SYNC : IDLE;
            WAIT_SYNC: begin
                if (!en) state_nx = IDLE;
                else if (sync_rise) begin
                    start_frame = 1'b1;
                    state_nx    = WAIT_SPCLK;
                end
            end
            WAIT_SPCLK: begin
                if (!en) state_nx = IDLE;
                else if (sync_rise) begin
                    start_frame = 1'b1;
                    set_sync    = 1'b1;
                end else if (spclk_rise) state_nx = CONV;
            end
            CONV: begin
                if (conv_vd) state_nx = SCAN;
                else if (tmo_cnt == '0) begin
                    timeout  = 1'b1;
                    state_nx = WAIT_SYNC;
                end
            end
            SCAN:       state_nx = (rem != '0) ? SCAN : !en ? IDLE : last_sample ? WAIT_SYNC : WAIT_SPCLK;
            default:    state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    // Datapath, output stream and sticky fault flags
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_d      <= 1'b0;
            spclk_d     <= 1'b0;
            conv_start  <= 1'b0;
            tmo_cnt     <= '0;
            mask_lat    <= '0;
            sample_cnt  <= '0;
            data_lat    <= '0;
            rem         <= '0;
            wr          <= 1'b0;
            wdata       <= '0;
            wchn        <= '0;
            sop         <= 1'b0;
            eop         <= 1'b0;
            frame_cnt   <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            err_sync    <= 1'b0;
        end else begin
            sync_d      <= sync;
            spclk_d     <= spclk;
            conv_start  <= go_conv;
            tmo_cnt     <= go_conv ? 16'(TIMEOUT) : (state == CONV && tmo_cnt != '0) ? tmo_cnt - 16'd1 : tmo_cnt;
            mask_lat    <= start_frame ? ((chn_mask == '0) ? {{(CHN_NUM-1){1'b0}}, 1'b1} : chn_mask) : mask_lat;
            sample_cnt  <= start_frame ? '0 : (state == SCAN && rem == '0 && !last_sample) ? sample_cnt + 8'd1 : sample_cnt;
            data_lat    <= (state == CONV && conv_vd) ? conv_data : data_lat;
            rem         <= emit ? rest : rem;
            wr          <= emit;
            wdata       <= emit ? src_data[int'(idx) * DATA_NBIT +: DATA_NBIT] : wdata;
            wchn        <= emit ? idx : wchn;
            sop         <= emit && state == CONV && sample_cnt == '0;
            eop         <= emit && last_word && last_sample;
            frame_cnt   <= frame_cnt + 16'(emit && last_word && last_sample);
            err_timeout <= !clear_err && (err_timeout || timeout);
            err_overrun <= !clear_err && (err_overrun || (spclk_rise && (state == CONV || state == SCAN)));
            err_sync    <= !clear_err && (err_sync || set_sync);
        end
    end
endmodule
